instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Instruction fetch front end sitting directly upstream of the CPU datapath.
//   - Issues sequential word fetches to the instruction memory.
//   - Buffers returned words in a small prefetch FIFO.
//   - Presents instr/pc/next_pc to decode with a valid/ready handshake.
//   - On a branch/jump redirect: flushes the FIFO and discards responses still in flight.
// PARAMETERS
//   ADDR_W    32  width of pc / memory address
//   DATA_W    32  instruction word width
//   DEPTH     4   prefetch FIFO entries; also max outstanding + buffered (power of 2, >=2)
//   RESET_PC  0   fetch address after reset
// PORTS
//   clk             in   1       clock, rising edge
//   reset           in   1       asynchronous, active-low reset (0 = in reset)
//   imem_req_valid  out  1       fetch request valid
//   imem_req_ready  in   1       memory accepts request
//   imem_req_addr   out  ADDR_W  word-aligned fetch address
//   imem_rsp_valid  in   1       response valid; in request order, latency >=1 cycle
//   imem_rsp_data   in   DATA_W  returned instruction word
//   redirect_valid  in   1       taken branch/jump from execute
//   redirect_pc     in   ADDR_W  new fetch address (bits[1:0] ignored, forced 0)
//   instr_valid     out  1       head entry valid
//   instr_ready     in   1       decode consumes head entry
//   instr           out  DATA_W  head instruction word
//   pc              out  ADDR_W  address of head instruction
//   next_pc         out  ADDR_W  pc + 4 (mod 2^ADDR_W)
// BEHAVIOUR
//   Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=0,
//     pc=RESET_PC, next_pc=RESET_PC+4; FIFO empty; outstanding=0; drop_cnt=0; state=RUN.
//   Issue rule: imem_req_valid=1 iff (fifo_count + outstanding) < DEPTH and no redirect this cycle.
//     Request fires on valid&ready; fetch_pc += 4 on fire (wraps at 2^ADDR_W).
//     While not fired, addr stays stable.
//   Response: when rsp_valid and drop_cnt==0, push {fetch addr, data} into FIFO;
//     outstanding -= 1. No overflow possible by the issue rule.
//   Output: instr/pc are the FIFO head, combinationally from storage.
//     - Pop on instr_valid & instr_ready.
//     - Push and pop in the same cycle keep the count unchanged.
//     - Push into an empty FIFO is visible the next cycle (min fetch-to-decode latency = mem latency + 1).
//   Redirect (takes effect at the clock edge where redirect_valid=1):
//     - FIFO cleared. A same-cycle pop is ignored; a same-cycle push is dropped.
//     - drop_cnt <= outstanding (including any request firing this cycle, minus any response arriving this cycle).
//     - outstanding <= 0; fetch_pc <= {redirect_pc[ADDR_W-1:2],2'b00}; pc output follows.
//     - No request is issued that cycle. instr_valid=0 on the following cycle.
//   FSM: RUN -> DRAIN when a redirect leaves drop_cnt>0.
//     DRAIN: each rsp_valid decrements drop_cnt, data is discarded.
//     DRAIN -> RUN when drop_cnt reaches 0. New requests may issue in DRAIN; ordering guarantees drops come first.
//     Redirect in DRAIN: drop_cnt accumulates (drop_cnt + outstanding).
//   Reset mid-operation: all state returns to reset values immediately; in-flight responses after reset release are not expected.
// CONFIGURATION
//   FETCH_PERF_EN defined: adds outputs perf_fetched[31:0] and perf_flushed[31:0], both reset to 0.
//     - perf_fetched: +1 per pop.
//     - perf_flushed: +1 per entry cleared from the FIFO plus +1 per dropped response.
//     - Both wrap at 2^32.
//   FETCH_PERF_EN undefined: ports and counters absent; all other behaviour is identical.
// TESTING
//   1 Reset: hold reset=0 for 5 cycles -> instr_valid=0, imem_req_valid=0, pc=0; release -> first request addr=0x0.
//   2 Stream: 1-cycle memory, instr_ready=1, ROM[i]=i -> pc=0,4,8,... one instruction per cycle after fill; next_pc=pc+4.
//   3 Backpressure: instr_ready=0 for 10 cycles -> exactly DEPTH=4 entries buffered;
//     imem_req_valid=0 once full; release -> words 0..3 pop in order, no loss.
//   4 Redirect in flight: 3-cycle memory, 3 outstanding, redirect_pc=0x40 -> next 3 responses dropped;
//     first valid instr has pc=0x40; perf_flushed = flushed + 3.
//   5 Simultaneous: redirect in the same cycle as pop and rsp_valid -> pop ignored, rsp dropped,
//     instr_valid=0 next cycle, then pc=redirect_pc.
//   6 Wrap + mid-op reset: redirect_pc=0xFFFFFFFC -> pc sequence 0xFFFFFFFC, 0x0;
//     reset asserted mid-stream -> pc=RESET_PC and FIFO empty immediately.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential fetch, prefetch FIFO, redirect flush.
// Define FETCH_PERF_EN to add the perf_fetched / perf_flushed counters.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    // Headroom for several back-to-back redirects while stale words drain.
    localparam int DROP_W = CNT_W + 4;
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(4);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] rsp_pc_q;
    logic [CNT_W-1:0]  out_q;
    logic [CNT_W-1:0]  count_q;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;

    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];

    logic [ADDR_W-1:0] redirect_addr;
    logic [CNT_W:0]    occupancy;
    logic              req_fire;
    logic              rsp_take;
    logic              rsp_drop;
    logic              push;
    logic              pop;
    logic              unused_redirect_lsb;

    assign redirect_addr       = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign occupancy      = {1'b0, count_q} + {1'b0, out_q};
    assign imem_req_valid = reset && !redirect_valid && (occupancy < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_take = imem_rsp_valid && (state_q == RUN);
    assign rsp_drop = imem_rsp_valid && (state_q == DRAIN);
    assign push     = rsp_take && !redirect_valid;

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    // When empty, pc shows the address of the next word to arrive.
    assign instr   = instr_valid ? fifo_data[rd_ptr_q] : '0;
    assign pc      = instr_valid ? fifo_pc[rd_ptr_q] : rsp_pc_q;
    assign next_pc = pc + STEP;

    always_comb begin
        drop_d  = drop_q;
        state_d = state_q;
        if (redirect_valid) begin
            drop_d = drop_q - DROP_W'(rsp_drop)
                   + DROP_W'(out_q) - DROP_W'(rsp_take);
        end else if (rsp_drop) begin
            drop_d = drop_q - DROP_W'(1);
        end
        unique case (state_q)
            RUN: begin
                if (drop_d != '0) state_d = DRAIN;
            end
            DRAIN: begin
                if (drop_d == '0) state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            drop_q     <= '0;
            out_q      <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (redirect_valid) begin
                out_q      <= '0;
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                fetch_pc_q <= redirect_addr;
                rsp_pc_q   <= redirect_addr;
            end else begin
                out_q   <= out_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
                if (req_fire) fetch_pc_q <= fetch_pc_q + STEP;
                if (push) begin
                    rsp_pc_q <= rsp_pc_q + STEP;
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]   <= rsp_pc_q;
            fifo_data[wr_ptr_q] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (pop) perf_fetched <= perf_fetched + 32'd1;
            perf_flushed <= perf_flushed
                          + (redirect_valid ? 32'(count_q) : 32'd0)
                          + 32'(rsp_drop || (rsp_take && redirect_valid));
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scripted stimulus, a latency-configurable
// memory and a stream-level reference model checked every cycle.
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] next_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    instr_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc             (pc),
        .next_pc        (next_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] pops[$];
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    int          live = 0;
    int          avail = 0;
    int          dropped = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_req = RESET_PC;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic chk_pop(input string name, input int idx,
                           input logic [31:0] exp);
        if (idx < pops.size()) begin
            chk(name, pops[idx], exp);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: pop %0d missing, want %08h", name, idx, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory + reference model: live = words owed to decode since the
    // last redirect (buffered or in flight); avail = words ready to pop.
    always @(negedge clk) begin
        mreq_t head;
        logic  fire;
        logic  pop_ev;
        logic  take;
        if (!reset) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            exp_pc  = RESET_PC;
            exp_req = RESET_PC;
            live    = 0;
            avail   = 0;
            #1;
            chk("rst_instr_valid", 32'(instr_valid), 32'd0);
            chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
            chk("rst_req_addr", imem_req_addr, RESET_PC);
            chk("rst_pc", pc, RESET_PC);
            chk("rst_next_pc", next_pc, RESET_PC + 32'd4);
            chk("rst_instr", instr, 32'd0);
        end else begin
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mq[0].addr >> 2;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            #1;
            chk("req_valid", 32'(imem_req_valid),
                32'((live < DEPTH) && !redirect_valid));
            if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
            chk("instr_valid", 32'(instr_valid), 32'(avail > 0));
            if (instr_valid) begin
                chk("pc", pc, exp_pc);
                chk("instr", instr, exp_pc >> 2);
            end
            chk("next_pc", next_pc, pc + 32'd4);

            fire   = imem_req_valid && imem_req_ready;
            pop_ev = instr_valid && instr_ready && !redirect_valid;
            take   = 1'b0;
            if (imem_rsp_valid) begin
                head = mq.pop_front();
                if (head.epoch == epoch && !redirect_valid) take = 1'b1;
                else dropped++;
            end
            if (redirect_valid) begin
                epoch++;
                exp_pc  = {redirect_pc[31:2], 2'b00};
                exp_req = exp_pc;
                live    = 0;
                avail   = 0;
            end else begin
                if (fire) begin
                    mq.push_back('{exp_req, cyc + lat, epoch});
                    exp_req += 32'd4;
                    live++;
                end
                if (pop_ev) begin
                    pops.push_back(pc);
                    exp_pc += 32'd4;
                    live--;
                    avail--;
                end
                if (take) avail++;
            end
        end
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1);
    end

    initial begin
        int          n0;
        int          d0;
        logic [31:0] held;

        reset          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;

        // Reset hold and first request
        step(5);
        chk("t1_instr_valid", 32'(instr_valid), 32'd0);
        chk("t1_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t1_pc", pc, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        #2;
        chk("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_first_req_addr", imem_req_addr, 32'h0);

        // Streaming with 1-cycle memory
        step(10);
        n0 = pops.size();
        step(8);
        chk("t2_throughput", 32'(pops.size() - n0), 32'd8);
        for (int i = 0; i < 4; i++) chk_pop("t2_pc_seq", i, 32'(i * 4));

        // Backpressure
        instr_ready = 1'b0;
        step(10);
        chk("t3_req_blocked", 32'(imem_req_valid), 32'd0);
        chk("t3_valid_held", 32'(instr_valid), 32'd1);
        chk("t3_buffered", 32'(avail), 32'd4);
        held        = pc;
        instr_ready = 1'b1;
        n0          = pops.size();
        step(4);
        for (int k = 0; k < 4; k++)
            chk_pop("t3_release_seq", n0 + k, held + 32'(4 * k));

        // Redirect with three requests in flight on a 3-cycle memory
        imem_req_ready = 1'b0;
        step(8);
        chk("t4_idle", 32'(instr_valid), 32'd0);
        lat            = 3;
        imem_req_ready = 1'b1;
        step(3);
        chk("t4_outstanding", 32'(live), 32'd3);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        d0             = dropped;
        step(1);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        chk("t4_flush_valid", 32'(instr_valid), 32'd0);
        n0 = pops.size();
        step(12);
        chk("t4_dropped", 32'(dropped - d0), 32'd3);
        chk_pop("t4_first_pc", n0, 32'h40);

        // Redirect colliding with pop and response
        lat = 1;
        step(8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        @(negedge clk);
        #2;
        chk("t5_pop_pending", 32'(instr_valid), 32'd1);
        chk("t5_rsp_pending", 32'(imem_rsp_valid), 32'd1);
        chk("t5_no_req", 32'(imem_req_valid), 32'd0);
        step(1);
        redirect_valid = 1'b0;
        chk("t5_valid_off", 32'(instr_valid), 32'd0);
        chk("t5_pc_follows", pc, 32'h200);
        n0 = pops.size();
        step(6);
        chk_pop("t5_first_pc", n0, 32'h200);

        // Address wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step(1);
        redirect_valid = 1'b0;
        n0 = pops.size();
        step(8);
        chk_pop("t6_wrap_top", n0, 32'hFFFF_FFFC);
        chk_pop("t6_wrap_zero", n0 + 1, 32'h0);

        // Asynchronous reset mid-stream
        chk("t6_busy", 32'(instr_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_pc", pc, RESET_PC);
        chk("t6_rst_valid", 32'(instr_valid), 32'd0);
        chk("t6_rst_req", 32'(imem_req_valid), 32'd0);
        step(3);
        reset = 1'b1;
        n0 = pops.size();
        step(8);
        chk_pop("t6_restart0", n0, 32'h0);
        chk_pop("t6_restart1", n0 + 1, 32'h4);

        // Back-to-back redirects while stale words drain
        lat = 3;
        step(10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step(1);
        redirect_pc    = 32'hC0;
        step(1);
        redirect_valid = 1'b0;
        n0 = pops.size();
        step(16);
        chk_pop("t7_first_pc", n0, 32'hC0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
